// File: rtl/adc_sample_sequencer.sv
// Periodic dual-channel ADC conversion scheduler: averages 2^AVG_LOG2 sample
// pairs and streams each averaged pair as a 4-byte packet to the UART transmitter.
module adc_sample_sequencer #(
  parameter int unsigned SAMPLE_DIV  = 50000,
  parameter int unsigned AVG_LOG2    = 2,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        start,
  input  logic        done,
  input  logic [11:0] data1,
  input  logic [11:0] data2,
  output logic        TxD_start,
  output logic [7:0]  TxD_data,
  input  logic        TxD_busy,
  output logic [7:0]  ovr_cnt,
  output logic [7:0]  tmo_cnt
);

  localparam int unsigned TW = $clog2(SAMPLE_DIV);
  localparam int unsigned WW = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned AW = 12 + AVG_LOG2;
  localparam int unsigned NW = AVG_LOG2 + 1;
  localparam logic [NW-1:0] N_FULL = NW'(2 ** AVG_LOG2);

  typedef enum logic {ADC_IDLE, ADC_WAIT} adc_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_GUARD, TX_DRAIN} tx_state_e;

  adc_state_e      adc_q;
  tx_state_e       tx_q;
  logic [TW-1:0]   timer_q;
  logic [WW-1:0]   wait_q;
  logic            done_q;
  logic [AW-1:0]   acc1_q, acc2_q;
  logic [NW-1:0]   n_q;
  logic [3:0][7:0] pkt_q;
  logic [1:0]      idx_q;
  logic [1:0]      seq_q;
  logic            ovr_flag_q, tmo_flag_q;
  logic            start_q, txs_q;
  logic [7:0]      txd_q, ovr_q, tmo_q;

  logic            tick, done_edge, capture, timeout, avg_full, load, drop;
  logic [AW-1:0]   acc1_d, acc2_d;
  logic [11:0]     avg1, avg2;

  assign tick      = en && (timer_q == TW'(SAMPLE_DIV - 1));
  assign done_edge = done && !done_q;
  assign capture   = (adc_q == ADC_WAIT) && done_edge;
  // A done edge wins over a timeout landing in the same cycle.
  assign timeout   = (adc_q == ADC_WAIT) && !done_edge && (wait_q == WW'(TIMEOUT_CYC - 1));
  assign avg_full  = (n_q == N_FULL);
  assign load      = avg_full && (tx_q == TX_IDLE);
  assign drop      = avg_full && (tx_q != TX_IDLE);
  assign acc1_d    = acc1_q + AW'(data1);
  assign acc2_d    = acc2_q + AW'(data2);
  assign avg1      = 12'(acc1_q >> AVG_LOG2);
  assign avg2      = 12'(acc2_q >> AVG_LOG2);

  always_ff @(posedge clk) begin
    if (!rst) begin
      adc_q      <= ADC_IDLE;
      tx_q       <= TX_IDLE;
      timer_q    <= '0;
      wait_q     <= '0;
      done_q     <= 1'b0;
      acc1_q     <= '0;
      acc2_q     <= '0;
      n_q        <= '0;
      pkt_q      <= '0;
      idx_q      <= '0;
      seq_q      <= '0;
      ovr_flag_q <= 1'b0;
      tmo_flag_q <= 1'b0;
      start_q    <= 1'b0;
      txs_q      <= 1'b0;
      txd_q      <= '0;
      ovr_q      <= '0;
      tmo_q      <= '0;
    end else begin
      done_q  <= done;
      start_q <= 1'b0;
      txs_q   <= 1'b0;

      if (!en || tick) timer_q <= '0;
      else             timer_q <= timer_q + TW'(1);

      case (adc_q)
        ADC_IDLE: begin
          if (tick) begin
            start_q <= 1'b1;
            wait_q  <= '0;
            adc_q   <= ADC_WAIT;
          end
        end
        ADC_WAIT: begin
          if (capture || timeout) adc_q  <= ADC_IDLE;
          else                    wait_q <= wait_q + WW'(1);
        end
        default: adc_q <= ADC_IDLE;
      endcase

      // Partial averages are discarded once disabled and no conversion is in flight.
      if (avg_full || (!en && adc_q == ADC_IDLE)) begin
        acc1_q <= '0;
        acc2_q <= '0;
        n_q    <= '0;
      end else if (capture) begin
        acc1_q <= acc1_d;
        acc2_q <= acc2_d;
        n_q    <= n_q + NW'(1);
      end

      tmo_flag_q <= (tmo_flag_q && !load) || timeout;
      ovr_flag_q <= (ovr_flag_q && !load) || drop;
      if (timeout && tmo_q != 8'hFF) tmo_q <= tmo_q + 8'd1;
      if (drop && ovr_q != 8'hFF)    ovr_q <= ovr_q + 8'd1;

      case (tx_q)
        TX_IDLE: begin
          if (load) begin
            pkt_q[0] <= {4'hA, ovr_flag_q, tmo_flag_q, seq_q};
            pkt_q[1] <= avg1[11:4];
            pkt_q[2] <= {avg1[3:0], avg2[11:8]};
            pkt_q[3] <= avg2[7:0];
            idx_q    <= '0;
            seq_q    <= seq_q + 2'd1;
            tx_q     <= TX_LOAD;
          end
        end
        TX_LOAD: begin
          if (!TxD_busy) begin
            txd_q <= pkt_q[idx_q];
            txs_q <= 1'b1;
            tx_q  <= TX_GUARD;
          end
        end
        // The transmitter asserts busy one cycle after start; skip that cycle.
        TX_GUARD: tx_q <= TX_DRAIN;
        TX_DRAIN: begin
          if (!TxD_busy) begin
            if (idx_q == 2'd3) begin
              tx_q <= TX_IDLE;
            end else begin
              idx_q <= idx_q + 2'd1;
              tx_q  <= TX_LOAD;
            end
          end
        end
        default: tx_q <= TX_IDLE;
      endcase
    end
  end

  assign start     = start_q;
  assign TxD_start = txs_q;
  assign TxD_data  = txd_q;
  assign ovr_cnt   = ovr_q;
  assign tmo_cnt   = tmo_q;

endmodule
